// File: rtl/if_prefetch_queue_pkg.sv
// if_pkg: shared types, NOP bubble constant and branch predecode for the prefetch queue.
package if_pkg;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD, S_BSTALL} state_t;

    localparam logic [31:0] NOP = 32'h0100_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } entry_t;

    function automatic logic is_branch(logic [31:0] w);
        return (w[31:30] == 2'b01) && (w[24:22] == 3'b001);
    endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// if_prefetch_queue_if: fetch-side bundle (cache request/response, decode handshake, redirect).
interface if_prefetch_queue_if #(
    parameter int ADDR_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] entry;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  br_resolved;
    logic                  ic_req;
    logic [ADDR_WIDTH-7:0] ic_line_addr;
    logic [3:0]            ic_word_select;
    logic                  ic_ack;
    logic [31:0]           ic_data_out;
    logic                  inst_valid;
    logic [31:0]           inst;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  id_ready;
    logic                  if_ready;

    modport master (
        input  entry, redirect_valid, redirect_target, br_resolved, ic_ack, ic_data_out, id_ready,
        output ic_req, ic_line_addr, ic_word_select, inst_valid, inst, inst_pc, if_ready
    );

    modport slave (
        output entry, redirect_valid, redirect_target, br_resolved, ic_ack, ic_data_out, id_ready,
        input  ic_req, ic_line_addr, ic_word_select, inst_valid, inst, inst_pc, if_ready
    );
endinterface

// File: rtl/if_queue.sv
// if_queue: circular FIFO with flush; pointers carry an extra wrap bit so full/empty need no counter.
module if_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr, rd;

    assign count = wr - rd;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = wr == rd;
    assign dout  = mem[rd[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wr <= '0;
            rd <= '0;
        end else if (flush) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (push && !full) wr <= wr + 1'b1;
            if (pop && !empty) rd <= rd + 1'b1;
        end

    always_ff @(posedge clk)
        if (push && !full && !flush) mem[wr[AW-1:0]] <= din;

endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: instruction prefetch FSM feeding an if_queue.
// Optional branch-stall predecode is enabled by defining IF_BRANCH_STALL_EN.
module if_prefetch_queue
    import if_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 64,
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] NOP_INST    = NOP
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] entry,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    input  logic                  br_resolved,
    output logic                  ic_req,
    output logic [ADDR_WIDTH-7:0] ic_line_addr,
    output logic [3:0]            ic_word_select,
    input  logic                  ic_ack,
    input  logic [31:0]           ic_data_out,
    output logic                  inst_valid,
    output logic [31:0]           inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  id_ready,
    output logic                  if_ready
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_n, req_pc, req_pc_n, target;
    logic                  req_n, push, pop, full, empty, stall, unused;
    logic [CW-1:0]         count;
    entry_t                head, din;

    assign target = {redirect_target[ADDR_WIDTH-1:2], 2'b00};
    assign pop    = ~empty & id_ready & ~redirect_valid;
    assign din    = '{pc: 64'(req_pc), inst: ic_data_out};
    assign unused = ^{redirect_target[1:0], req_pc[1:0], full};

`ifdef IF_BRANCH_STALL_EN
    assign stall = is_branch(ic_data_out);
`else
    assign stall = 1'b0;
`endif

    // req_pc is the address on the bus; fetch_pc may move ahead of it while a stale request drains
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        req_pc_n   = req_pc;
        req_n      = ic_req;
        push       = 1'b0;
        if (redirect_valid) begin
            fetch_pc_n = target;
            if (ic_req && !ic_ack) state_n = S_DISCARD;
            else begin
                state_n  = S_REQ;
                req_n    = 1'b1;
                req_pc_n = target;
            end
        end else begin
            case (state)
                S_IDLE: if (int'(count) < QUEUE_DEPTH) begin
                    state_n  = S_REQ;
                    req_n    = 1'b1;
                    req_pc_n = fetch_pc;
                end
                S_REQ: if (ic_ack) begin
                    push       = 1'b1;
                    fetch_pc_n = req_pc + ADDR_WIDTH'(4);
                    req_pc_n   = fetch_pc_n;
                    if (stall) begin
                        state_n = S_BSTALL;
                        req_n   = 1'b0;
                    end else if (int'(count) + 1 - int'(pop) >= QUEUE_DEPTH) begin
                        state_n = S_IDLE;
                        req_n   = 1'b0;
                    end
                end
                S_DISCARD: if (ic_ack) begin
                    state_n  = S_REQ;
                    req_pc_n = fetch_pc;
                end
                S_BSTALL: if (br_resolved) state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state    <= S_IDLE;
            fetch_pc <= entry;
            req_pc   <= entry;
            ic_req   <= 1'b0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            req_pc   <= req_pc_n;
            ic_req   <= req_n;
        end

    if_queue #(.DEPTH(QUEUE_DEPTH), .WIDTH($bits(entry_t))) u_queue (
        .clk(clk),
        .reset_n(reset_n),
        .push(push),
        .pop(pop),
        .flush(redirect_valid),
        .din(din),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(count)
    );

    assign ic_line_addr   = req_pc[ADDR_WIDTH-1:6];
    assign ic_word_select = req_pc[5:2];
    assign inst_valid     = ~empty;
    assign inst           = empty ? NOP_INST : head.inst;
    assign inst_pc        = empty ? '0 : head.pc[ADDR_WIDTH-1:0];
    assign if_ready       = ~empty & (state != S_DISCARD);

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed + randomized checks of the prefetch queue against a PC-stream model.
module tb_if_prefetch_queue;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] addr, bpc, expc, tgt, prev_addr;
    logic        started, redir, prev_hold;
    int          total = 0, bad = 0, acc, pops;

    if_prefetch_queue_if #(.ADDR_WIDTH(64)) bus ();

    if_prefetch_queue dut (
        .clk(clk),
        .reset_n(reset_n),
        .entry(bus.entry),
        .redirect_valid(bus.redirect_valid),
        .redirect_target(bus.redirect_target),
        .br_resolved(bus.br_resolved),
        .ic_req(bus.ic_req),
        .ic_line_addr(bus.ic_line_addr),
        .ic_word_select(bus.ic_word_select),
        .ic_ack(bus.ic_ack),
        .ic_data_out(bus.ic_data_out),
        .inst_valid(bus.inst_valid),
        .inst(bus.inst),
        .inst_pc(bus.inst_pc),
        .id_ready(bus.id_ready),
        .if_ready(bus.if_ready)
    );

    always #5 clk = ~clk;

    assign addr = {bus.ic_line_addr, bus.ic_word_select, 2'b00};

    // Memory image: every word encodes its own address, so stale or misplaced words are visible
    function automatic logic [31:0] mem(input logic [63:0] pc);
        return (pc == bpc) ? 32'h4040_0000 : {2'b10, pc[31:2]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_on();
        bus.ic_ack      = bus.ic_req;
        bus.ic_data_out = mem(addr);
    endtask

    task automatic hold_reset(input logic [63:0] e);
        reset_n             = 1'b0;
        bus.entry           = e;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.br_resolved     = 1'b0;
        bus.ic_ack          = 1'b0;
        bus.ic_data_out     = '0;
        bus.id_ready        = 1'b0;
        #1;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && !bus.ic_req; i++) tick();
        chk(tag, bus.ic_req, 1);
    endtask

    initial begin
        bpc = '1;
        // reset values
        hold_reset(64'h1000);
        tick();
        tick();
        chk("rst_ic_req", bus.ic_req, 0);
        chk("rst_inst_valid", bus.inst_valid, 0);
        chk("rst_inst", bus.inst, 32'h0100_0000);
        chk("rst_inst_pc", bus.inst_pc, 0);
        chk("rst_if_ready", bus.if_ready, 0);
        reset_n = 1'b1;
        wait_req("first_req");
        chk("first_line", bus.ic_line_addr, 58'h40);
        chk("first_word", bus.ic_word_select, 0);
        chk("first_inst_nop", bus.inst, 32'h0100_0000);

        // back-to-back fetch, decode always ready
        expc = 64'h1000; started = 0; pops = 0;
        for (int i = 0; i < 40; i++) begin
            bus.id_ready = 1'b1;
            ack_on();
            if (bus.inst_valid) begin
                chk("b2b_pc", bus.inst_pc, expc);
                chk("b2b_inst", bus.inst, mem(expc));
                expc += 4; pops++; started = 1;
            end else if (started) chk("b2b_bubble", bus.inst_valid, 1);
            tick();
        end
        chk("b2b_count", pops >= 38, 1);

        // full queue: reset asserted mid-request, then decode stalled
        reset_n = 1'b0;
        #1;
        chk("rst_async_req", bus.ic_req, 0);
        chk("rst_async_valid", bus.inst_valid, 0);
        hold_reset(64'h1000);
        tick();
        reset_n = 1'b1;
        acc = 0;
        for (int i = 0; i < 14; i++) begin
            ack_on();
            acc += int'(bus.ic_ack);
            tick();
        end
        bus.ic_ack = 1'b0;
        chk("full_acks", acc, 4);
        chk("full_req_low", bus.ic_req, 0);
        chk("full_head", bus.inst_pc, 64'h1000);
        chk("full_if_ready", bus.if_ready, 1);
        bus.id_ready = 1'b1;
        tick();
        bus.id_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            ack_on();
            acc += int'(bus.ic_ack);
            tick();
        end
        bus.ic_ack = 1'b0;
        chk("pulse_acks", acc, 1);
        chk("pulse_head", bus.inst_pc, 64'h1004);
        chk("pulse_req_low", bus.ic_req, 0);

        // redirect while a request is in flight
        hold_reset(64'h1000);
        tick();
        reset_n = 1'b1;
        wait_req("rd_req");
        chk("rd_addr0", addr, 64'h1000);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 64'h2003;
        tick();
        bus.redirect_valid = 1'b0;
        chk("rd_hold_req", bus.ic_req, 1);
        chk("rd_hold_addr", addr, 64'h1000);
        chk("rd_if_ready", bus.if_ready, 0);
        bus.ic_ack = 1'b1; bus.ic_data_out = mem(64'h1000);
        tick();
        bus.ic_ack = 1'b0;
        chk("rd_stale_dropped", bus.inst_valid, 0);
        chk("rd_reissue", bus.ic_req, 1);
        chk("rd_new_addr", addr, 64'h2000);
        bus.ic_ack = 1'b1; bus.ic_data_out = mem(64'h2000);
        tick();
        bus.ic_ack = 1'b0;
        chk("rd_valid", bus.inst_valid, 1);
        chk("rd_head_pc", bus.inst_pc, 64'h2000);
        chk("rd_head_inst", bus.inst, mem(64'h2000));

        // redirect + ack + id_ready in the same cycle
        chk("sim_addr", addr, 64'h2004);
        bus.id_ready = 1'b1; bus.ic_ack = 1'b1; bus.ic_data_out = mem(64'h2004);
        bus.redirect_valid = 1'b1; bus.redirect_target = 64'h5000;
        tick();
        bus.id_ready = 1'b0; bus.ic_ack = 1'b0; bus.redirect_valid = 1'b0;
        chk("sim_flushed", bus.inst_valid, 0);
        chk("sim_req", bus.ic_req, 1);
        chk("sim_addr_new", addr, 64'h5000);
        bus.ic_ack = 1'b1; bus.ic_data_out = mem(64'h5000);
        tick();
        bus.ic_ack = 1'b0;
        chk("sim_head_pc", bus.inst_pc, 64'h5000);

        // randomized traffic against the in-order PC stream model
        hold_reset(64'h8000);
        tick();
        reset_n = 1'b1;
        expc = 64'h8000; pops = 0; prev_hold = 0; prev_addr = '0;
        for (int i = 0; i < 3000; i++) begin
            redir = ($urandom % 50) == 0;
            tgt = {$urandom, $urandom};
            bus.redirect_valid  = redir;
            bus.redirect_target = tgt;
            bus.id_ready        = ($urandom % 3) != 0;
            bus.ic_ack          = bus.ic_req && (($urandom % 5) < 3);
            bus.ic_data_out     = mem(addr);
            if (prev_hold) begin
                chk("rnd_req_held", bus.ic_req, 1);
                chk("rnd_addr_stable", addr, prev_addr);
            end
            if (!bus.inst_valid) chk("rnd_nop", bus.inst, 32'h0100_0000);
            if (bus.inst_valid && bus.id_ready && !redir) begin
                chk("rnd_pc", bus.inst_pc, expc);
                chk("rnd_inst", bus.inst, mem(expc));
                expc += 4; pops++;
            end
            if (redir) expc = {tgt[63:2], 2'b00};
            prev_hold = bus.ic_req && !bus.ic_ack;
            prev_addr = addr;
            tick();
        end
        bus.redirect_valid = 1'b0; bus.ic_ack = 1'b0; bus.id_ready = 1'b0;
        chk("rnd_progress", pops > 500, 1);

`ifdef IF_BRANCH_STALL_EN
        hold_reset(64'h1000);
        bpc = 64'h1000;
        tick();
        reset_n = 1'b1;
        bus.id_ready = 1'b1;
        wait_req("br_req");
        ack_on();
        tick();
        bus.ic_ack = 1'b0;
        chk("br_enq_pc", bus.inst_pc, 64'h1000);
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            acc += int'(bus.ic_req);
            tick();
        end
        chk("br_stalled", acc, 0);
        chk("br_drained", bus.inst_valid, 0);
        bus.br_resolved = 1'b1;
        tick();
        bus.br_resolved = 1'b0;
        wait_req("br_resume");
        chk("br_resume_addr", addr, 64'h1004);
        bpc = '1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
